// File: rtl/gw_video_pkg.sv
// Shared video-fetch definitions: FSM state encoding, line geometry defaults
// and the line-base address helper.
package gw_video_pkg;

  localparam int unsigned DefWordsPerLine = 2160;
  localparam int unsigned DefVisibleLines = 720;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StBurst,
    StGap,
    StAbort
  } fetch_state_e;

  // Lines outside the visible range alias to line 0.
  function automatic logic [24:0] line_base(input logic [9:0] y, input int unsigned words,
                                            input int unsigned lines);
    if (32'(y) >= lines) return '0;
    return 25'(y) * 25'(words);
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Assembles three 16-bit SDRAM words into one 24-bit background pixel (low bytes)
// and one 24-bit mask pixel (high bytes); first word lands in bits [7:0].
module pixel_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic [15:0] word,
  output logic [23:0] bg_pixel,
  output logic [23:0] mask_pixel,
  output logic        pixel_valid
);

  logic [1:0] word_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      bg_pixel    <= '0;
      mask_pixel  <= '0;
      word_cnt    <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      if (push) begin
        bg_pixel   <= {word[7:0], bg_pixel[23:8]};
        mask_pixel <= {word[15:8], mask_pixel[23:8]};
        if (word_cnt == 2'd2) begin
          word_cnt    <= '0;
          pixel_valid <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/line_fetch_scheduler.sv
// Fetches one display line per line_start from burst SDRAM port 0 and slots
// single download writes into the gaps between bursts.
module line_fetch_scheduler
  import gw_video_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DefWordsPerLine,
  parameter int unsigned VISIBLE_LINES  = DefVisibleLines
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_data,
  output logic        sd_wr_req,
  output logic        sd_rd_req,
  output logic        sd_end_burst,
  input  logic        sd_data_available,
  input  logic [15:0] sd_q,
  output logic [23:0] bg_pixel,
  output logic [23:0] mask_pixel,
  output logic        pixel_valid,
  output logic        fifo_clear,
  output logic        wr_overflow
);

  localparam logic [24:0] Wpl = 25'(WORDS_PER_LINE);

  fetch_state_e state;
  logic [9:0]   line_y_q;
  logic [24:0]  read_count;
  logic         da_q, rd_pend, ret_gap, end_sent, wr_pend;
  logic [24:0]  wr_addr_q;
  logic [15:0]  wr_data_q;

  logic         accept_ls, word_ok, go_write, go_read;
  logic [9:0]   next_line;
  logic [24:0]  next_count, base_q, base_next;

  always_comb begin
    accept_ls  = line_start & ~ioctl_download;
    next_line  = accept_ls ? line_y : line_y_q;
    next_count = accept_ls ? '0 : read_count;
    base_q     = line_base(line_y_q, WORDS_PER_LINE, VISIBLE_LINES);
    base_next  = line_base(next_line, WORDS_PER_LINE, VISIBLE_LINES);
    word_ok    = (state == StBurst) && sd_data_available && !accept_ls && (read_count < Wpl);
    go_write   = wr_pend && ((state == StIdle) || (state == StGap));
  end

  always_comb begin
    go_read = 1'b0;
    case (state)
      StIdle:  go_read = !wr_pend && accept_ls;
      StWrite: go_read = !ioctl_download &&
                         (rd_pend || accept_ls || (ret_gap && (next_count < Wpl)));
      StGap:   go_read = !wr_pend && !ioctl_download && (next_count < Wpl);
      StAbort: go_read = !ioctl_download && !sd_data_available;
      default: go_read = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      line_y_q     <= '0;
      read_count   <= '0;
      da_q         <= 1'b0;
      rd_pend      <= 1'b0;
      ret_gap      <= 1'b0;
      end_sent     <= 1'b0;
      wr_pend      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sd_addr      <= '0;
      sd_data      <= '0;
      sd_wr_req    <= 1'b0;
      sd_rd_req    <= 1'b0;
      sd_end_burst <= 1'b0;
      fifo_clear   <= 1'b0;
      wr_overflow  <= 1'b0;
    end else begin
      sd_rd_req    <= 1'b0;
      sd_wr_req    <= 1'b0;
      sd_end_burst <= 1'b0;
      fifo_clear   <= line_start;
      da_q         <= sd_data_available;

      if (accept_ls) begin
        line_y_q   <= line_y;
        read_count <= '0;
      end
      if (ioctl_download) rd_pend <= 1'b0;

      // Single-entry buffer; frees on the same edge the write is issued.
      if (ioctl_wr) begin
        if (wr_pend && !go_write) begin
          wr_overflow <= 1'b1;
        end else begin
          wr_pend   <= 1'b1;
          wr_addr_q <= ioctl_addr;
          wr_data_q <= ioctl_dout;
        end
      end else if (go_write) begin
        wr_pend <= 1'b0;
      end

      if (go_write) begin
        state     <= StWrite;
        ret_gap   <= (state == StGap);
        rd_pend   <= accept_ls;
        sd_wr_req <= 1'b1;
        sd_addr   <= wr_addr_q;
        sd_data   <= wr_data_q;
      end else if (go_read) begin
        state     <= StReadReq;
        sd_rd_req <= 1'b1;
        sd_addr   <= base_next + next_count;
        rd_pend   <= 1'b0;
        end_sent  <= 1'b0;
      end else begin
        case (state)
          StWrite, StGap: state <= StIdle;
          StReadReq:      state <= StBurst;
          StBurst: begin
            if (accept_ls) begin
              sd_end_burst <= 1'b1;
              state        <= StAbort;
            end else begin
              if (word_ok) begin
                read_count <= read_count + 25'd1;
                sd_addr    <= base_q + read_count + 25'd1;
                if (!end_sent && (read_count >= Wpl - 25'd2)) begin
                  sd_end_burst <= 1'b1;
                  end_sent     <= 1'b1;
                end
              end
              if (da_q && !sd_data_available) state <= StGap;
            end
          end
          StAbort: if (ioctl_download) state <= StIdle;
          default: ;
        endcase
      end
    end
  end

  pixel_packer u_pixel_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (accept_ls),
    .push        (word_ok),
    .word        (sd_q),
    .bg_pixel    (bg_pixel),
    .mask_pixel  (mask_pixel),
    .pixel_valid (pixel_valid)
  );

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed bench for line_fetch_scheduler: cycle vector table followed by
// multi-cycle burst, gap, overflow, abort and reset sequences.
module tb_line_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [9:0]  line_y;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [24:0] sd_addr;
  logic [15:0] sd_data;
  logic        sd_wr_req, sd_rd_req, sd_end_burst;
  logic        sd_data_available;
  logic [15:0] sd_q;
  logic [23:0] bg_pixel, mask_pixel;
  logic        pixel_valid, fifo_clear, wr_overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  line_fetch_scheduler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .line_start        (line_start),
    .line_y            (line_y),
    .ioctl_download    (ioctl_download),
    .ioctl_wr          (ioctl_wr),
    .ioctl_addr        (ioctl_addr),
    .ioctl_dout        (ioctl_dout),
    .sd_addr           (sd_addr),
    .sd_data           (sd_data),
    .sd_wr_req         (sd_wr_req),
    .sd_rd_req         (sd_rd_req),
    .sd_end_burst      (sd_end_burst),
    .sd_data_available (sd_data_available),
    .sd_q              (sd_q),
    .bg_pixel          (bg_pixel),
    .mask_pixel        (mask_pixel),
    .pixel_valid       (pixel_valid),
    .fifo_clear        (fifo_clear),
    .wr_overflow       (wr_overflow)
  );

  typedef struct {
    logic        ls;
    logic [9:0]  ly;
    logic        dl;
    logic        wr;
    logic [24:0] wa;
    logic [15:0] wd;
    logic        da;
    logic [15:0] q;
    logic [4:0]  pulses;  // {rd, wr, end_burst, fifo_clear, pixel_valid}
    logic [24:0] addr;
    logic [15:0] data;
    logic [23:0] bg;
    logic [23:0] mk;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mv(logic ls, logic [9:0] ly, logic dl, logic wr, logic [24:0] wa,
                              logic [15:0] wd, logic da, logic [15:0] q, logic [4:0] pulses,
                              logic [24:0] addr, logic [15:0] data, logic [23:0] bg,
                              logic [23:0] mk);
    vec_t v;
    v.ls = ls; v.ly = ly; v.dl = dl; v.wr = wr; v.wa = wa; v.wd = wd; v.da = da; v.q = q;
    v.pulses = pulses; v.addr = addr; v.data = data; v.bg = bg; v.mk = mk;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int eb_cnt, eb_idx, pv_cnt, rd_seen, wr_seen;

  initial begin
    vecs[0]  = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 0,       0,        0,          0);
    vecs[1]  = mv(0, 0,   0, 1, 25'h123, 16'hBEEF, 0, 0,        5'b00000, 0,       0,        0,          0);
    vecs[2]  = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b01000, 25'h123, 16'hBEEF, 0,          0);
    vecs[3]  = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 25'h123, 16'hBEEF, 0,          0);
    vecs[4]  = mv(1, 800, 0, 0, 0,       0,        0, 0,        5'b10010, 0,       16'hBEEF, 0,          0);
    vecs[5]  = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 0,       16'hBEEF, 0,          0);
    vecs[6]  = mv(0, 0,   0, 0, 0,       0,        1, 16'h11AA, 5'b00000, 1,       16'hBEEF, 24'hAA0000, 24'h110000);
    vecs[7]  = mv(0, 0,   0, 0, 0,       0,        1, 16'h22BB, 5'b00000, 2,       16'hBEEF, 24'hBBAA00, 24'h221100);
    vecs[8]  = mv(0, 0,   0, 0, 0,       0,        1, 16'h33CC, 5'b00001, 3,       16'hBEEF, 24'hCCBBAA, 24'h332211);
    vecs[9]  = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 3,       16'hBEEF, 24'hCCBBAA, 24'h332211);
    vecs[10] = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b10000, 3,       16'hBEEF, 24'hCCBBAA, 24'h332211);
    vecs[11] = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 3,       16'hBEEF, 24'hCCBBAA, 24'h332211);
    vecs[12] = mv(1, 2,   0, 0, 0,       0,        0, 0,        5'b00110, 3,       16'hBEEF, 0,          0);
    vecs[13] = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b10000, 4320,    16'hBEEF, 0,          0);
    vecs[14] = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 4320,    16'hBEEF, 0,          0);
    vecs[15] = mv(1, 5,   1, 0, 0,       0,        0, 0,        5'b00010, 4320,    16'hBEEF, 0,          0);
    vecs[16] = mv(0, 0,   1, 0, 0,       0,        1, 16'h0102, 5'b00000, 4321,    16'hBEEF, 24'h020000, 24'h010000);
    vecs[17] = mv(0, 0,   1, 0, 0,       0,        0, 0,        5'b00000, 4321,    16'hBEEF, 24'h020000, 24'h010000);
    vecs[18] = mv(0, 0,   1, 0, 0,       0,        0, 0,        5'b00000, 4321,    16'hBEEF, 24'h020000, 24'h010000);
    vecs[19] = mv(1, 3,   1, 0, 0,       0,        0, 0,        5'b00010, 4321,    16'hBEEF, 24'h020000, 24'h010000);
    vecs[20] = mv(0, 0,   0, 0, 0,       0,        0, 0,        5'b00000, 4321,    16'hBEEF, 24'h020000, 24'h010000);

    reset_n = 1'b0; line_start = 1'b0; line_y = '0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; sd_data_available = 1'b0; sd_q = '0;
    step();
    step();
    chk("reset pulses", 64'({sd_rd_req, sd_wr_req, sd_end_burst, fifo_clear, pixel_valid}), 0);
    chk("reset addr", 64'(sd_addr), 0);
    chk("reset pixels", {sd_data, bg_pixel, mask_pixel}, 0);
    chk("reset overflow", 64'(wr_overflow), 0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      line_start = vecs[i].ls; line_y = vecs[i].ly; ioctl_download = vecs[i].dl;
      ioctl_wr = vecs[i].wr; ioctl_addr = vecs[i].wa; ioctl_dout = vecs[i].wd;
      sd_data_available = vecs[i].da; sd_q = vecs[i].q;
      step();
      chk($sformatf("vec%0d ctrl", i),
          {34'b0, sd_rd_req, sd_wr_req, sd_end_burst, fifo_clear, pixel_valid, sd_addr},
          {34'b0, vecs[i].pulses, vecs[i].addr});
      chk($sformatf("vec%0d data", i), {sd_data, bg_pixel, mask_pixel},
          {vecs[i].data, vecs[i].bg, vecs[i].mk});
    end
    line_start = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; sd_data_available = 1'b0;

    // Full line 1 with continuous data, two surplus words at the end.
    line_start = 1'b1; line_y = 10'd1;
    step();
    line_start = 1'b0;
    chk("line1 rd_req", 64'(sd_rd_req), 1);
    chk("line1 addr", 64'(sd_addr), 2160);
    step();
    eb_cnt = 0; eb_idx = -1; pv_cnt = 0;
    for (int i = 0; i < 2162; i++) begin
      sd_data_available = 1'b1; sd_q = 16'(i);
      step();
      if (sd_end_burst) begin eb_cnt++; eb_idx = i; end
      if (pixel_valid) pv_cnt++;
    end
    sd_data_available = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sd_rd_req) rd_seen++;
      if (pixel_valid) pv_cnt++;
    end
    chk("line1 end_burst count", 64'(eb_cnt), 1);
    chk("line1 end_burst word", 64'(eb_idx), 2158);
    chk("line1 pixel count", 64'(pv_cnt), 720);
    chk("line1 no re-request", 64'(rd_seen), 0);

    // Burst broken after 100 words, with two writes arriving mid-burst.
    line_start = 1'b1; line_y = 10'd4;
    step();
    line_start = 1'b0;
    chk("line4 addr", 64'(sd_addr), 8640);
    step();
    wr_seen = 0;
    for (int i = 0; i < 100; i++) begin
      sd_data_available = 1'b1; sd_q = 16'(i);
      ioctl_wr = (i == 10) || (i == 20);
      ioctl_addr = (i == 10) ? 25'h55 : 25'h66;
      ioctl_dout = (i == 10) ? 16'h1234 : 16'h9999;
      step();
      if (sd_wr_req) wr_seen++;
    end
    ioctl_wr = 1'b0;
    chk("no write in burst", 64'(wr_seen), 0);
    chk("overflow set", 64'(wr_overflow), 1);
    sd_data_available = 1'b0;
    step();
    chk("gap entry quiet", 64'({sd_rd_req, sd_wr_req}), 0);
    step();
    chk("gap write pulses", 64'({sd_rd_req, sd_wr_req}), 64'b01);
    chk("gap write addr", 64'(sd_addr), 25'h55);
    chk("gap write data", 64'(sd_data), 16'h1234);
    step();
    chk("re-request pulses", 64'({sd_rd_req, sd_wr_req}), 64'b10);
    chk("re-request addr", 64'(sd_addr), 8740);
    step();

    // Continue to word 500, then a new line_start aborts the burst.
    wr_seen = 0;
    for (int i = 100; i < 500; i++) begin
      sd_data_available = 1'b1; sd_q = 16'(i);
      step();
      if (sd_wr_req) wr_seen++;
    end
    chk("dropped write never issues", 64'(wr_seen), 0);
    line_start = 1'b1; line_y = 10'd6; sd_q = 16'hAAAA;
    step();
    line_start = 1'b0;
    chk("abort end_burst", 64'(sd_end_burst), 1);
    chk("abort fifo_clear", 64'(fifo_clear), 1);
    pv_cnt = 0; rd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      sd_q = 16'hEEEE;
      step();
      if (pixel_valid) pv_cnt++;
      if (sd_rd_req) rd_seen++;
    end
    chk("abort discards", 64'({pv_cnt[7:0], rd_seen[7:0], bg_pixel}), 0);
    sd_data_available = 1'b0;
    step();
    chk("new line rd_req", 64'(sd_rd_req), 1);
    chk("new line addr", 64'(sd_addr), 12960);
    step();
    sd_data_available = 1'b1; sd_q = 16'h11AA;
    step();
    chk("new line first word addr", 64'(sd_addr), 12961);
    chk("overflow sticky", 64'(wr_overflow), 1);

    // Reset in the middle of the burst.
    reset_n = 1'b0;
    step();
    chk("mid-burst reset pulses", 64'({sd_rd_req, sd_end_burst, pixel_valid, wr_overflow}), 0);
    chk("mid-burst reset regs", {sd_addr[15:0], bg_pixel, mask_pixel}, 0);
    reset_n = 1'b1; sd_data_available = 1'b0;
    step();
    step();
    chk("idle after reset", 64'({sd_rd_req, sd_wr_req, sd_end_burst}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_fetch_scheduler.md
LINE_FETCH_SCHEDULER -- requirements
Module: line_fetch_scheduler

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 2160, meaning 16-bit SDRAM words per display line (720 px x 3).
REQ-002 SHALL have parameter VISIBLE_LINES, default 720, meaning lines fetched per frame; line_y at or above this value fetches line 0.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses this single clock.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports line_start (in, 1, one-cycle pulse, fetch next line) and line_y (in, 10, line index sampled on line_start).
REQ-006 SHALL have ports ioctl_download (in, 1), ioctl_wr (in, 1), ioctl_addr (in, 25) and ioctl_dout (in, 16), the download write path.
REQ-007 SHALL have ports sd_addr (out, 25), sd_data (out, 16), sd_wr_req (out, 1), sd_rd_req (out, 1) and sd_end_burst (out, 1), which drive the burst SDRAM port 0.
REQ-008 SHALL have ports sd_data_available (in, 1) and sd_q (in, 16), the burst read return.
REQ-009 SHALL have ports bg_pixel (out, 24), mask_pixel (out, 24) and pixel_valid (out, 1), the assembled pixels sent to the FIFOs.
REQ-010 SHALL have ports fifo_clear (out, 1) and wr_overflow (out, 1, sticky).

Function
REQ-011 SHALL implement FSM IDLE, WRITE, READ_REQ, BURST, GAP, ABORT.
REQ-012 On a line_start pulse, the block SHALL latch line_y, zero read_count and the pixel shift state, and pulse fifo_clear for 1 cycle.
REQ-013 Line base word address SHALL be line_y x WORDS_PER_LINE, computed at 25-bit width; sd_addr SHALL equal base + read_count during reads and the pending write address during WRITE.
REQ-014 IDLE->READ_REQ SHALL occur on line_start when ioctl_download=0; READ_REQ SHALL pulse sd_rd_req for 1 cycle, then go to BURST.
REQ-015 In BURST, each cycle with sd_data_available=1 SHALL increment read_count and shift sd_q[7:0] into bg_pixel and sd_q[15:8] into mask_pixel, right-shift, so the first word ends in bits [7:0].
REQ-016 pixel_valid SHALL pulse 1 cycle after every third accepted word; bg_pixel and mask_pixel SHALL be stable during that pulse.
REQ-017 sd_end_burst SHALL pulse on an accepted word when read_count before the increment is at least WORDS_PER_LINE-2.
REQ-018 A falling edge of sd_data_available in BURST SHALL go to GAP; GAP SHALL go to READ_REQ if read_count < WORDS_PER_LINE, else to IDLE.
REQ-019 Words beyond WORDS_PER_LINE SHALL be discarded without pixel_valid.
REQ-020 An ioctl_wr pulse SHALL latch address and data into a single-entry pending buffer; a second write while that buffer is occupied SHALL set wr_overflow and be dropped.
REQ-021 A pending write SHALL be issued from IDLE or GAP, and never during BURST: WRITE pulses sd_wr_req for 1 cycle, then returns to the interrupted state's successor (GAP->READ_REQ check, IDLE->IDLE).
REQ-022 Simultaneous pending write and read request in GAP or IDLE SHALL resolve with the write winning.
REQ-023 A line_start during BURST SHALL pulse sd_end_burst and enter ABORT; ABORT SHALL discard words until sd_data_available=0, then enter READ_REQ for the new line.
REQ-024 While ioctl_download=1, no reads SHALL be issued, and any line_start is ignored apart from the fifo_clear pulse.
REQ-025 sd_rd_req, sd_wr_req and sd_end_burst SHALL be one-cycle pulses, and sd_rd_req and sd_wr_req SHALL never be high in the same cycle.

Reset
REQ-026 With reset_n=0 at a clk edge, state SHALL be IDLE and all outputs, counters, pixel registers and wr_overflow SHALL be 0, with the pending buffer empty.
REQ-027 Reset mid-burst SHALL abandon the burst with no end_burst pulse; SDRAM-side recovery belongs to the SDRAM block.

Structure
REQ-028 The FSM state enum, WORDS_PER_LINE and VISIBLE_LINES defaults SHALL live in shared package gw_video_pkg.
REQ-029 Pixel byte assembly (shift registers, 2-bit word counter, pixel_valid) SHALL be sub-module pixel_packer; all else SHALL stay inline.

Verification
REQ-030 line_start with line_y=1 and continuous data_available: first sd_rd_req with sd_addr=2160; end_burst on the word with read_count=2158; 720 pixel_valid pulses.
REQ-031 line_y=800: sd_addr starts at 0.
REQ-032 Words 0x11AA, 0x22BB, 0x33CC: bg_pixel=0xCCBBAA and mask_pixel=0x332211 on pixel_valid.
REQ-033 Burst broken after 100 words: GAP, then re-request at sd_addr=base+100; an ioctl_wr pending during the burst issues in GAP before the re-request.
REQ-034 Two ioctl_wr pulses during a burst: the first issues after the burst, the second is dropped, and wr_overflow=1 until reset.
REQ-035 line_start at word 500: sd_end_burst pulses, residual words are discarded, and the new read starts at the new base with read_count=0.
